// File: rtl/px_pkg.sv
// Shared definitions for the P-X bus interface controller family:
// controller state encoding and the round-robin pick helper.
package px_pkg;

    localparam int unsigned MAX_CH = 8;
    localparam int unsigned IW     = 3;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        XFER,
        DONE,
        HOLD,
        ALARM
    } state_t;

    // First pending index strictly after 'last', wrapping modulo nch.
    // Returns 'last' when nothing is pending; callers gate on |pend.
    function automatic logic [IW-1:0] rr_next(
        input logic [MAX_CH-1:0] pend,
        input logic [IW-1:0]     last,
        input int unsigned       nch
    );
        logic [IW-1:0] pick;
        logic          found;
        int unsigned   idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_CH; k++) begin
            if (k <= nch) begin
                idx = (32'(last) + k) % nch;
                if (!found && pend[idx[IW-1:0]]) begin
                    pick  = idx[IW-1:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin channel picker: combinational choice from the pending set
// plus the register remembering the last channel granted.
module rr_arb
    import px_pkg::*;
#(
    parameter int unsigned NCH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] pending,
    input  logic           take,
    output logic [IW-1:0]  pick
);

    logic [IW-1:0] last;

    always_comb begin
        pick = rr_next(MAX_CH'(pending), last, NCH);
    end

    // Starting at NCH-1 makes channel 0 the first winner after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= IW'(NCH - 1);
        end else if (take) begin
            last <= pick;
        end
    end

endmodule

// File: rtl/ifctl_nch.sv
// Multi-channel system-bus interface controller: round-robin arbitration,
// ZG/ZW handshake, reply/timeout sequencing and per-channel bus hold.
module ifctl_nch
    import px_pkg::*;
#(
    parameter int unsigned NCH             = 2,
    parameter int unsigned CW              = 8,
    parameter int unsigned ALARM_DLY_TICKS = 200,
    parameter int unsigned ALARM_TICKS     = 3
) (
    input  logic           clk_sys,
    input  logic           clo_n,
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] hold,
    input  logic [NCH-1:0] hold_rel,
    input  logic           zw,
    input  logic           ren,
    input  logic           rok,
    input  logic           rpe,
    output logic           zg,
    output logic [NCH-1:0] zwzg,
    output logic           ok$,
    output logic [NCH-1:0] talarm,
    output logic [NCH-1:0] pending
);

    state_t         state;
    logic [IW-1:0]  sel;
    logic [IW-1:0]  pick;
    logic [NCH-1:0] sel_oh;
    logic [CW-1:0]  tcnt;
    logic [CW-1:0]  acnt;
    logic           hold_lat;
    logic           reply;
    logic           pend_sel;
    logic           take;
    logic           xfer_go;

    always_comb begin
        reply  = ren | rok | rpe;
        sel_oh = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            sel_oh[i] = (IW'(i) == sel);
        end
        pend_sel = |(pending & sel_oh);
        take     = (state == IDLE) && (|pending);
        xfer_go  = ((state == REQ) && zw) || ((state == HOLD) && pend_sel);
    end

    rr_arb #(.NCH(NCH)) u_arb (
        .clk     (clk_sys),
        .rst_n   (clo_n),
        .pending (pending),
        .take    (take),
        .pick    (pick)
    );

    // A req arriving on the XFER-entry tick re-queues the same channel.
    always_ff @(posedge clk_sys or negedge clo_n) begin
        if (!clo_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~(xfer_go ? sel_oh : '0)) | req;
        end
    end

    always_ff @(posedge clk_sys or negedge clo_n) begin
        if (!clo_n) begin
            state    <= IDLE;
            sel      <= '0;
            tcnt     <= '0;
            acnt     <= '0;
            hold_lat <= 1'b0;
            zg       <= 1'b0;
            zwzg     <= '0;
            ok$      <= 1'b0;
            talarm   <= '0;
        end else begin
            ok$ <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        sel   <= pick;
                        zg    <= 1'b1;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (zw) begin
                        zwzg  <= sel_oh;
                        tcnt  <= '0;
                        state <= XFER;
                    end
                end
                XFER: begin
                    // Reply takes priority over a timeout on the same tick.
                    if (reply) begin
                        ok$      <= 1'b1;
                        hold_lat <= |(hold & sel_oh);
                        state    <= DONE;
                    end else if (tcnt == CW'(ALARM_DLY_TICKS - 1)) begin
                        tcnt   <= tcnt + 1'b1;
                        zg     <= 1'b0;
                        zwzg   <= '0;
                        talarm <= sel_oh;
                        acnt   <= '0;
                        state  <= ALARM;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DONE: begin
                    if (!reply) begin
                        if (hold_lat) begin
                            state <= HOLD;
                        end else begin
                            zg    <= 1'b0;
                            zwzg  <= '0;
                            state <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (pend_sel) begin
                        tcnt  <= '0;
                        state <= XFER;
                    end else if (|(hold_rel & sel_oh)) begin
                        zg    <= 1'b0;
                        zwzg  <= '0;
                        state <= IDLE;
                    end
                end
                ALARM: begin
                    if (acnt == CW'(ALARM_TICKS - 1)) begin
                        talarm <= '0;
                        state  <= IDLE;
                    end else begin
                        acnt <= acnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifctl_nch.sv
// Bench for ifctl_nch: an abstract per-tick model of the bus handshake is
// compared every cycle, alongside hand-computed literal expectations.
module tb_ifctl_nch;

    localparam int unsigned NCH = 2;
    localparam int unsigned DLY = 10;
    localparam int unsigned ATK = 3;

    logic           clk = 1'b0;
    logic           clo_n;
    logic [NCH-1:0] req, hold, hold_rel;
    logic           zw, ren, rok, rpe;
    logic           zg, ok;
    logic [NCH-1:0] zwzg, talarm, pending;

    int errors = 0;
    int checks = 0;
    bit run = 1'b0;

    always #5 clk = ~clk;

    ifctl_nch #(
        .NCH(NCH), .CW(8), .ALARM_DLY_TICKS(DLY), .ALARM_TICKS(ATK)
    ) dut (
        .clk_sys(clk), .clo_n(clo_n), .req(req), .hold(hold),
        .hold_rel(hold_rel), .zw(zw), .ren(ren), .rok(rok), .rpe(rpe),
        .zg(zg), .zwzg(zwzg), .ok$(ok), .talarm(talarm), .pending(pending)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: owner channel plus phase flags (waiting for grant, transferring,
    // awaiting reply release, parked on hold, alarming).
    bit             m_want, m_xfer, m_done, m_held, m_alarm, m_hlat, m_ok;
    int             m_own, m_last, m_tcnt, m_acnt;
    logic [NCH-1:0] m_pend, m_clr;
    bit             m_rep;

    always @(posedge clk or negedge clo_n) begin
        if (!clo_n) begin
            {m_want, m_xfer, m_done, m_held, m_alarm, m_hlat, m_ok} = '0;
            m_own = 0; m_last = NCH - 1; m_tcnt = 0; m_acnt = 0; m_pend = '0;
        end else begin
            m_clr = '0;
            m_rep = ren | rok | rpe;
            m_ok  = 1'b0;
            if (m_want) begin
                if (zw) begin
                    m_want = 0; m_xfer = 1; m_tcnt = 0; m_clr[m_own] = 1'b1;
                end
            end else if (m_xfer) begin
                if (m_rep) begin
                    m_xfer = 0; m_done = 1; m_ok = 1; m_hlat = hold[m_own];
                end else begin
                    m_tcnt++;
                    if (m_tcnt == DLY) begin
                        m_xfer = 0; m_alarm = 1; m_acnt = 0;
                    end
                end
            end else if (m_done) begin
                if (!m_rep) begin
                    m_done = 0; m_held = m_hlat;
                end
            end else if (m_held) begin
                if (m_pend[m_own]) begin
                    m_held = 0; m_xfer = 1; m_tcnt = 0; m_clr[m_own] = 1'b1;
                end else if (hold_rel[m_own]) begin
                    m_held = 0;
                end
            end else if (m_alarm) begin
                m_acnt++;
                if (m_acnt == ATK) m_alarm = 0;
            end else if (m_pend != '0) begin
                for (int k = NCH; k >= 1; k--) begin
                    if (m_pend[(m_last + k) % NCH]) m_own = (m_last + k) % NCH;
                end
                m_last = m_own;
                m_want = 1;
            end
            m_pend = (m_pend & ~m_clr) | req;
        end
    end

    always @(negedge clk) begin
        logic [NCH-1:0] oh;
        if (clo_n && run) begin
            oh = NCH'(1) << m_own;
            chk("model zg", 32'(zg), 32'(m_want | m_xfer | m_done | m_held));
            chk("model zwzg", 32'(zwzg), 32'((m_xfer | m_done | m_held) ? oh : '0));
            chk("model ok", 32'(ok), 32'(m_ok));
            chk("model talarm", 32'(talarm), 32'(m_alarm ? oh : '0));
            chk("model pending", 32'(pending), 32'(m_pend));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_zg(input string nm);
        int k = 0;
        while (zg !== 1'b1 && k < 30) begin tick(1); k++; end
        chk({nm, " zg up"}, 32'(zg), 1);
    endtask

    task automatic wait_free(input string nm);
        int k = 0;
        while (zwzg !== '0 && k < 30) begin tick(1); k++; end
        chk({nm, " bus free"}, 32'(zwzg), 0);
    endtask

    task automatic serve(input logic [NCH-1:0] exp_oh, input string nm);
        wait_zg(nm);
        zw = 1'b1; tick(1); zw = 1'b0;
        chk({nm, " owner"}, 32'(zwzg), 32'(exp_oh));
        tick(1);
        rok = 1'b1; tick(1); rok = 1'b0;
        chk({nm, " ok"}, 32'(ok), 1);
        wait_free(nm);
    endtask

    task automatic do_reset();
        @(negedge clk); #2 clo_n = 1'b0;
        tick(2); #2 clo_n = 1'b1;
        tick(1);
    endtask

    initial begin
        int first, cnt;
        req = '0; hold = '0; hold_rel = '0;
        zw = 1'b0; ren = 1'b0; rok = 1'b0; rpe = 1'b0;
        clo_n = 1'b0;
        tick(2); #2 clo_n = 1'b1; run = 1'b1;
        tick(1);
        chk("reset zg", 32'(zg), 0);
        chk("reset zwzg", 32'(zwzg), 0);
        chk("reset pending", 32'(pending), 0);
        chk("reset talarm", 32'(talarm), 0);

        // Single channel 0 transfer.
        req = 2'b01; tick(1); req = '0;
        chk("t1 pending", 32'(pending), 1);
        tick(1);
        chk("t1 zg", 32'(zg), 1);
        tick(2);
        zw = 1'b1; tick(1); zw = 1'b0;
        chk("t1 zwzg", 32'(zwzg), 1);
        tick(4);
        rok = 1'b1; tick(1); rok = 1'b0;
        chk("t1 ok", 32'(ok), 1);
        tick(1);
        chk("t1 ok end", 32'(ok), 0);
        chk("t1 zwzg end", 32'(zwzg), 0);
        chk("t1 zg end", 32'(zg), 0);

        // Round-robin alternation over 4 simultaneous pairs.
        do_reset();
        for (int r = 0; r < 4; r++) begin
            req = 2'b11; tick(1); req = '0;
            serve(2'b01, "rr ch0");
            serve(2'b10, "rr ch1");
        end

        // Hold on channel 1, back-to-back transfer, then release.
        hold = 2'b10;
        req = 2'b10; tick(1); req = '0;
        wait_zg("hold1");
        zw = 1'b1; tick(1); zw = 1'b0;
        chk("hold1 owner", 32'(zwzg), 32'(2'b10));
        tick(1);
        rok = 1'b1; tick(1); rok = 1'b0;
        chk("hold1 ok", 32'(ok), 1);
        tick(1);
        for (int k = 0; k < 3; k++) begin
            chk("hold keep zg", 32'(zg), 1);
            chk("hold keep zwzg", 32'(zwzg), 32'(2'b10));
            tick(1);
        end
        req = 2'b10; tick(1); req = '0;
        hold_rel = 2'b10; tick(1); hold_rel = '0;
        chk("hold xfer2 zwzg", 32'(zwzg), 32'(2'b10));
        chk("hold xfer2 pending", 32'(pending), 0);
        tick(2);
        rok = 1'b1; tick(1); rok = 1'b0;
        chk("hold2 ok", 32'(ok), 1);
        tick(2);
        chk("hold2 parked", 32'(zwzg), 32'(2'b10));
        hold_rel = 2'b10; tick(1); hold_rel = '0;
        chk("hold rel zg", 32'(zg), 0);
        chk("hold rel zwzg", 32'(zwzg), 0);
        hold = '0;

        // Timeout: no reply.
        req = 2'b01; tick(1); req = '0;
        wait_zg("alarm");
        zw = 1'b1; tick(1); zw = 1'b0;
        first = -1; cnt = 0;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            if (talarm == 2'b01) begin
                if (first < 0) first = k;
                cnt++;
            end
            if (k == 10) chk("alarm zg low", 32'(zg), 0);
        end
        chk("alarm start", 32'(first), 10);
        chk("alarm len", 32'(cnt), 3);
        chk("alarm idle", 32'(zwzg), 0);

        // Reply on the very tick the timeout limit is reached.
        req = 2'b01; tick(1); req = '0;
        wait_zg("edge");
        zw = 1'b1; tick(1); zw = 1'b0;
        tick(9);
        rok = 1'b1; tick(1); rok = 1'b0;
        chk("edge ok", 32'(ok), 1);
        chk("edge talarm", 32'(talarm), 0);
        tick(4);
        wait_free("edge");

        // Asynchronous clear mid-transfer with a request queued.
        req = 2'b01; tick(1); req = '0;
        wait_zg("rst");
        zw = 1'b1; tick(1); zw = 1'b0;
        req = 2'b10; tick(1); req = '0;
        tick(2);
        #2 clo_n = 1'b0;
        #1;
        chk("async zg", 32'(zg), 0);
        chk("async zwzg", 32'(zwzg), 0);
        chk("async pending", 32'(pending), 0);
        chk("async ok", 32'(ok), 0);
        chk("async talarm", 32'(talarm), 0);
        tick(2); #2 clo_n = 1'b1;
        tick(3);
        chk("post rst pending", 32'(pending), 0);
        chk("post rst zg", 32'(zg), 0);
        req = 2'b11; tick(1); req = '0;
        serve(2'b01, "post rst ch0");
        serve(2'b10, "post rst ch1");

        tick(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
